// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//
// Purpose:
//   Shared definitions for the multi-cycle shift controller (shift_seq) and
//   its single-step datapath (shift_seq_shifter):
//     - default operand / shift-amount widths
//     - shift op encodings
//     - FSM state encodings
//     - helper that tells a real shift op apart from NOP / unknown codes
//
// Ports:
//   none (package)
// -----------------------------------------------------------------------------
package shift_pkg;

    // Default datapath sizing.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_AMT_W = 5;

    // Shift op encoding, shared with the execute-stage decoder.
    typedef logic [2:0] sh_op_t;

    localparam sh_op_t SH_NOP = 3'b000;
    localparam sh_op_t SH_LSL = 3'b001;
    localparam sh_op_t SH_LSR = 3'b010;
    localparam sh_op_t SH_ASR = 3'b011;
    localparam sh_op_t SH_ROR = 3'b101;

    // FSM state encoding. Plain localparam constants keep the encoding
    // visible to older tools and to anyone poking at a netlist.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // True only for the four real shift ops. Codes 100, 110 and 111 are not
    // assigned and behave exactly like SH_NOP.
    function automatic logic sh_is_shift(input sh_op_t op);
        logic hit;
        hit = 1'b0;
        case (op)
            SH_LSL, SH_LSR, SH_ASR, SH_ROR: hit = 1'b1;
            default:                        hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage : shift_pkg

// File: rtl/shift_seq_shifter.sv
// -----------------------------------------------------------------------------
// shift_seq_shifter
//
// Purpose:
//   Purely combinational single-step shifter. Moves the operand by exactly
//   one bit position according to the shift op and reports the bit that fell
//   off plus a signed-overflow flag for left shifts.
//
// Ports:
//   in        input  [WIDTH-1:0]  operand for this step
//   sh        input  [2:0]        shift op (shift_pkg::SH_*)
//   out       output [WIDTH-1:0]  operand shifted by one bit
//   cout      output              bit shifted out on this step
//   overflow  output              LSL only: sign bit changes on this step
//
// Unknown ops and SH_NOP pass the operand through with cout/overflow low.
// -----------------------------------------------------------------------------
module shift_seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       sh,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             overflow
);

    always_comb begin
        out      = in;
        cout     = 1'b0;
        overflow = 1'b0;
        case (sh)
            SH_LSL: begin
                out      = {in[WIDTH-2:0], 1'b0};
                cout     = in[WIDTH-1];
                // The new sign bit is the old bit WIDTH-2; overflow when the
                // two differ, i.e. the sign flips on this step.
                overflow = in[WIDTH-1] ^ in[WIDTH-2];
            end
            SH_LSR: begin
                out  = {1'b0, in[WIDTH-1:1]};
                cout = in[0];
            end
            SH_ASR: begin
                out  = {in[WIDTH-1], in[WIDTH-1:1]};
                cout = in[0];
            end
            SH_ROR: begin
                out  = {in[0], in[WIDTH-1:1]};
                cout = in[0];
            end
            default: begin
                out      = in;
                cout     = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule : shift_seq_shifter

// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq
//
// Purpose:
//   Multi-cycle shift controller for the ALU path. Latches one operand, a
//   shift op and a shift amount, then steps a single-bit shifter once per
//   clock until the amount is consumed. The result is offered to the
//   writeback mux with a valid/ready handshake, together with the final
//   carry-out and a sticky overflow (OR over every step).
//
// Ports:
//   clk        input              system clock, rising edge
//   rst_n      input              asynchronous active-low reset
//   flush      input              synchronous abort, back to IDLE, result dropped
//   start      input              job request, accepted only while busy=0
//   op         input  [2:0]       shift op, latched on accept
//   amt        input  [AMT_W-1:0] shift count, latched on accept
//   data_in    input  [WIDTH-1:0] operand, latched on accept
//   busy       output             high in every state except IDLE
//   res_valid  output             result available, held until res_ready
//   res_ready  input              consumer takes the result
//   result     output [WIDTH-1:0] shifted operand
//   cout       output             last bit shifted out
//   overflow   output             sticky OR of per-step shifter overflow
//
// Timing:
//   start accepted -> res_valid after amt+1 cycles; 1 cycle for amt==0 or a
//   non-shift op. All outputs come from registers only.
// -----------------------------------------------------------------------------
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AMT_W = DEF_AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [2:0]       op_q,    op_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    // Single-step shifter outputs
    logic [WIDTH-1:0] step_out;
    logic             step_cout;
    logic             step_ovf;

    // -------------------------------------------------------------------------
    // Single-step datapath: always fed from the accumulator and latched op.
    // -------------------------------------------------------------------------
    shift_seq_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .in       (acc_q),
        .sh       (op_q),
        .out      (step_out),
        .cout     (step_cout),
        .overflow (step_ovf)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        if (flush) begin
            // Abort wins over start and res_ready. The datapath registers
            // keep their contents; they are simply never presented.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_d  = data_in;
                        op_d   = op;
                        cnt_d  = amt;
                        cout_d = 1'b0;
                        ovf_d  = 1'b0;
                        // Nothing to step: go straight to DONE with the
                        // operand untouched and flags clear.
                        if ((amt == '0) || !sh_is_shift(op)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    acc_d  = step_out;
                    cout_d = step_cout;
                    ovf_d  = ovf_q | step_ovf;
                    cnt_d  = cnt_q - AMT_W'(1);
                    // cnt==1 means this edge writes the last step.
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end

                ST_DONE: begin
                    // A start seen here is dropped: the controller always
                    // passes through IDLE before the next accept.
                    if (res_ready) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            op_q    <= SH_NOP;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from registered state only. The result fields are
    // masked outside DONE so a flushed or in-flight job is never visible.
    // -------------------------------------------------------------------------
    logic in_done;

    assign in_done   = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = in_done;
    assign result    = in_done ? acc_q : '0;
    assign cout      = in_done & cout_q;
    assign overflow  = in_done & ovf_q;

endmodule : shift_seq
